// File: rtl/zap_thumb_fetch_sequencer.sv
// Buffers 32-bit fetch words and sequences them into halfword (T-state) or whole-word (ARM) decoder slots.
// Optional macro ZAP_THUMB_SEQ_PERF_EN adds the o_hw_count halfword-equivalent counter.
module zap_thumb_fetch_sequencer #(
    parameter int BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_stall,
    input  logic        i_cpsr_t,
    input  logic [31:0] i_word,
    input  logic [31:0] i_word_pc,
    input  logic        i_word_valid,
    input  logic        i_word_abort,
    output logic        o_word_ready,
    output logic [31:0] o_instruction,
    output logic        o_instruction_valid,
    output logic [31:0] o_pc,
    output logic        o_iabort,
    output logic        o_thumb
`ifdef ZAP_THUMB_SEQ_PERF_EN
    ,
    output logic [31:0] o_hw_count
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOW   = 2'd1,
        S_HIGH  = 2'd2
    } state_t;

    // Handshake: a word transfers on a cycle where i_word_valid && o_word_ready;
    // the I-cache must hold word, pc, abort and T stable until that cycle.

    logic [31:0]      buf_word  [BUF_DEPTH];
    logic [31:0]      buf_pc    [BUF_DEPTH];
    logic             buf_abort [BUF_DEPTH];
    logic             buf_t     [BUF_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count;

    state_t           state;
    state_t           state_nxt;
    state_t           cur_state;

    logic             push;
    logic             pop;
    logic             emit;
    logic             whole;

    logic [31:0]      hd_word;
    logic [31:0]      hd_pc;
    logic             hd_abort;
    logic             hd_t;

    logic [31:0]      slot_instr;
    logic [31:0]      slot_pc;
    logic             slot_abort;
    logic             slot_thumb;

    function automatic state_t entry_state(input logic t, input logic [31:0] pc, input logic abort);
        if (t && !abort) begin
            return pc[1] ? S_HIGH : S_LOW;
        end
        return S_HIGH;
    endfunction

    assign hd_word    = buf_word[rd_ptr];
    assign hd_pc      = buf_pc[rd_ptr];
    assign hd_abort   = buf_abort[rd_ptr];
    assign hd_t       = buf_t[rd_ptr];
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);

    always_comb begin
        o_word_ready = !i_reset && !i_clear && (count < DEPTH_C);
        push         = i_word_valid && o_word_ready;
        whole        = !hd_t || hd_abort;

        // S_EMPTY with a freshly written head resolves in the same cycle, giving one-cycle latency.
        cur_state = state;
        if (state == S_EMPTY && count != '0) begin
            cur_state = entry_state(hd_t, hd_pc, hd_abort);
        end

        emit       = !i_stall && (cur_state != S_EMPTY);
        pop        = emit && (cur_state == S_HIGH);
        state_nxt  = state;
        slot_instr = hd_word;
        slot_pc    = hd_pc;
        slot_abort = hd_abort;
        slot_thumb = hd_t;

        if (emit) begin
            case (cur_state)
                S_LOW: begin
                    slot_instr = {16'd0, hd_word[15:0]};
                    state_nxt  = S_HIGH;
                end
                S_HIGH: begin
                    if (!whole) begin
                        slot_instr = {16'd0, hd_word[31:16]};
                        slot_pc    = hd_pc[1] ? hd_pc : hd_pc + 32'd2;
                    end
                    state_nxt = (count > CNT_W'(1))
                              ? entry_state(buf_t[rd_ptr_inc], buf_pc[rd_ptr_inc], buf_abort[rd_ptr_inc])
                              : S_EMPTY;
                end
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_word[wr_ptr]  <= i_word;
            buf_pc[wr_ptr]    <= i_word_pc;
            buf_abort[wr_ptr] <= i_word_abort;
            buf_t[wr_ptr]     <= i_cpsr_t;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= S_EMPTY;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_instruction_valid <= 1'b0;
            o_instruction       <= '0;
            o_pc                <= '0;
            o_iabort            <= 1'b0;
            o_thumb             <= 1'b0;
        end else if (i_clear) begin
            o_instruction_valid <= 1'b0;
            o_iabort            <= 1'b0;
        end else if (!i_stall) begin
            o_instruction_valid <= emit;
            if (emit) begin
                o_instruction <= slot_instr;
                o_pc          <= slot_pc;
                o_iabort      <= slot_abort;
                o_thumb       <= slot_thumb;
            end
        end
    end

`ifdef ZAP_THUMB_SEQ_PERF_EN
    logic [32:0] hw_sum;

    // ARM slots count as two halfwords; the counter sticks at all-ones.
    assign hw_sum = {1'b0, o_hw_count} + (slot_thumb ? 33'd1 : 33'd2);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_hw_count <= '0;
        end else if (emit && !i_clear) begin
            o_hw_count <= hw_sum[32] ? 32'hFFFF_FFFF : hw_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_zap_thumb_fetch_sequencer.sv
// Scoreboard bench for zap_thumb_fetch_sequencer: expected slots are queued on word acceptance
// and compared as the output register loads.
module tb_zap_thumb_fetch_sequencer;

    localparam int W = 66;

    logic        i_clk;
    logic        i_reset;
    logic        i_clear;
    logic        i_stall;
    logic        i_cpsr_t;
    logic [31:0] i_word;
    logic [31:0] i_word_pc;
    logic        i_word_valid;
    logic        i_word_abort;
    logic        o_word_ready;
    logic [31:0] o_instruction;
    logic        o_instruction_valid;
    logic [31:0] o_pc;
    logic        o_iabort;
    logic        o_thumb;
`ifdef ZAP_THUMB_SEQ_PERF_EN
    logic [31:0] o_hw_count;
    logic [31:0] exp_hw = 0;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    zap_thumb_fetch_sequencer #(.BUF_DEPTH(2)) dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_clear             (i_clear),
        .i_stall             (i_stall),
        .i_cpsr_t            (i_cpsr_t),
        .i_word              (i_word),
        .i_word_pc           (i_word_pc),
        .i_word_valid        (i_word_valid),
        .i_word_abort        (i_word_abort),
        .o_word_ready        (o_word_ready),
        .o_instruction       (o_instruction),
        .o_instruction_valid (o_instruction_valid),
        .o_pc                (o_pc),
        .o_iabort            (o_iabort),
        .o_thumb             (o_thumb)
`ifdef ZAP_THUMB_SEQ_PERF_EN
        ,
        .o_hw_count          (o_hw_count)
`endif
    );

    // Clock and reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] pack_slot(input logic [31:0] ins, input logic [31:0] pc,
                                               input logic ab, input logic th);
        return {ins, pc, ab, th};
    endfunction

    task automatic push_expected(input logic [31:0] word, input logic [31:0] pc,
                                 input logic t, input logic abort);
        if (t && !abort) begin
            if (!pc[1]) begin
                exp_q.push_back(pack_slot({16'd0, word[15:0]}, pc, 1'b0, 1'b1));
                exp_q.push_back(pack_slot({16'd0, word[31:16]}, pc + 32'd2, 1'b0, 1'b1));
            end else begin
                exp_q.push_back(pack_slot({16'd0, word[31:16]}, pc, 1'b0, 1'b1));
            end
        end else begin
            exp_q.push_back(pack_slot(word, pc, abort, t));
        end
    endtask

    // Monitor: a slot is new only when the register was allowed to load on this edge
    logic         adv;
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_got;
    always @(posedge i_clk) begin
        adv = !(i_stall || i_clear || i_reset);
        #1;
        if (adv && o_instruction_valid) begin
            mon_got = pack_slot(o_instruction, o_pc, o_iabort, o_thumb);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL slot_unexpected: got %h expected no slot", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
`ifdef ZAP_THUMB_SEQ_PERF_EN
                exp_hw = exp_hw + (mon_exp[0] ? 32'd1 : 32'd2);
`endif
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL slot: got ins=%h pc=%h ab=%b th=%b expected ins=%h pc=%h ab=%b th=%b",
                             mon_got[65:34], mon_got[33:2], mon_got[1], mon_got[0],
                             mon_exp[65:34], mon_exp[33:2], mon_exp[1], mon_exp[0]);
                end
            end
        end
    end

    // Driver: called at a negedge, returns at the negedge after acceptance
    task automatic send_word(input logic [31:0] word, input logic [31:0] pc,
                             input logic t, input logic abort);
        logic acc;
        acc          = 1'b0;
        i_word       = word;
        i_word_pc    = pc;
        i_cpsr_t     = t;
        i_word_abort = abort;
        i_word_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            #1 acc = o_word_ready;
            @(posedge i_clk);
            if (acc) push_expected(word, pc, t, abort);
            @(negedge i_clk);
        end
        i_word_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept of %h expected accept", word);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge i_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending slots expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge i_clk);
        checks++;
        if (o_instruction_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_valid: got %b expected 0", name, o_instruction_valid);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        checks++;
        if ({o_instruction_valid, o_iabort, o_thumb, o_instruction, o_pc} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b ab=%b th=%b ins=%h pc=%h expected all 0",
                     o_instruction_valid, o_iabort, o_thumb, o_instruction, o_pc);
        end
        checks++;
        if (o_word_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", o_word_ready);
        end
`ifdef ZAP_THUMB_SEQ_PERF_EN
        checks++;
        if (o_hw_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_hw_count: got %h expected 0", o_hw_count);
        end
`endif
        @(negedge i_clk);
    endtask

    task automatic test_thumb_basic();
        send_word(32'hB0AA_4801, 32'h0000_0100, 1'b1, 1'b0);
        wait_drain("thumb_basic");
        send_word(32'h1234_5678, 32'h0000_0202, 1'b1, 1'b0);
        wait_drain("thumb_odd_pc");
    endtask

    task automatic test_arm_back_to_back();
        send_word(32'hE3A0_0001, 32'h0000_0000, 1'b0, 1'b0);
        send_word(32'hE3A0_1002, 32'h0000_0004, 1'b0, 1'b0);
        wait_drain("arm_b2b");
    endtask

    task automatic test_abort();
        send_word(32'hDEAD_BEEF, 32'h0000_0300, 1'b1, 1'b1);
        wait_drain("abort");
    endtask

    task automatic test_mixed_t();
        send_word(32'h1111_2222, 32'h0000_0500, 1'b1, 1'b0);
        send_word(32'hE1A0_0000, 32'h0000_0504, 1'b0, 1'b0);
        send_word(32'h3333_4444, 32'h0000_050A, 1'b1, 1'b0);
        send_word(32'h5555_6666, 32'hFFFF_FFFC, 1'b1, 1'b0);
        wait_drain("mixed_t");
    endtask

    task automatic test_stall_full();
        logic acc;
        i_stall = 1'b1;
        send_word(32'hA001_A000, 32'h0000_0600, 1'b1, 1'b0);
        send_word(32'hA003_A002, 32'h0000_0604, 1'b1, 1'b0);
        i_word       = 32'hA005_A004;
        i_word_pc    = 32'h0000_0608;
        i_cpsr_t     = 1'b1;
        i_word_abort = 1'b0;
        i_word_valid = 1'b1;
        #1;
        checks++;
        if (o_word_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_full_ready: got %b expected 0", o_word_ready);
        end
        @(negedge i_clk);
        checks++;
        if (o_word_ready !== 1'b0 || o_instruction_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_frozen: got ready=%b valid=%b expected ready=0 valid=0",
                     o_word_ready, o_instruction_valid);
        end
        i_stall = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1 acc = o_word_ready;
            @(posedge i_clk);
            if (acc) push_expected(32'hA005_A004, 32'h0000_0608, 1'b1, 1'b0);
            @(negedge i_clk);
        end
        i_word_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL stall_third_accept: got no accept expected accept after release");
        end
        wait_drain("stall_full");
    endtask

    task automatic test_clear();
        send_word(32'hCAFE_1111, 32'h0000_0400, 1'b1, 1'b0);
        @(negedge i_clk);
        // High half of the word is still pending; the flush discards it
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        i_clear      = 1'b1;
        i_word       = 32'hBAD0_BAD0;
        i_word_pc    = 32'h0000_0404;
        i_cpsr_t     = 1'b1;
        i_word_abort = 1'b0;
        i_word_valid = 1'b1;
        #1;
        checks++;
        if (o_word_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: got %b expected 0", o_word_ready);
        end
        @(negedge i_clk);
        i_clear      = 1'b0;
        i_word_valid = 1'b0;
        checks++;
        if (o_instruction_valid !== 1'b0 || o_iabort !== 1'b0 || dut.count !== '0) begin
            errors++;
            $display("FAIL clear_state: got valid=%b iabort=%b count=%0d expected 0 0 0",
                     o_instruction_valid, o_iabort, dut.count);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_instruction_valid !== 1'b0) begin
                errors++;
                $display("FAIL clear_quiet: got valid=%b expected 0", o_instruction_valid);
            end
        end
        send_word(32'h4770_2001, 32'h0000_0800, 1'b1, 1'b0);
        wait_drain("after_clear");
    endtask

    task automatic test_random();
        fork
            begin
                for (int n = 0; n < 24; n++) begin
                    send_word($urandom, $urandom & 32'hFFFF_FFFE, 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 7) == 0));
                end
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge i_clk);
                    i_stall = ($urandom_range(0, 3) == 0);
                end
                i_stall = 1'b0;
            end
        join
        i_stall = 1'b0;
        wait_drain("random");
    endtask

    initial begin
        i_reset      = 1'b1;
        i_clear      = 1'b0;
        i_stall      = 1'b0;
        i_cpsr_t     = 1'b0;
        i_word       = '0;
        i_word_pc    = '0;
        i_word_valid = 1'b0;
        i_word_abort = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_thumb_basic();
        test_arm_back_to_back();
        test_abort();
        test_mixed_t();
        test_stall_full();
        test_clear();
        test_random();
`ifdef ZAP_THUMB_SEQ_PERF_EN
        checks++;
        if (o_hw_count !== exp_hw) begin
            errors++;
            $display("FAIL hw_count: got %0d expected %0d", o_hw_count, exp_hw);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zap_thumb_fetch_sequencer.md
Name: zap_thumb_fetch_sequencer

Overview:
Sits between the I-cache fetch stage and the 16-bit instruction decoder. Buffers 32-bit fetch words and sequences them into one or two decoder slots. In T-state a word yields a low then a high halfword; in ARM state each word passes through whole. Owns the fetch-side handshake: it backpressures the I-cache when its buffer is full and flushes on pipeline clear.

Parameters:
BUF_DEPTH, 2, number of 32-bit word entries in the input FIFO (power of 2, >=2).

Ports:
i_clk  in  1  core clock
i_reset  in  1  synchronous active-high reset
i_clear  in  1  pipeline flush (writeback/ALU/decode clear, pre-ORed)
i_stall  in  1  downstream stall; hold output register
i_cpsr_t  in  1  T bit; sampled per word at acceptance
i_word  in  32  fetched word
i_word_pc  in  32  byte address of the first valid halfword in i_word
i_word_valid  in  1  fetch word qualifier
i_word_abort  in  1  instruction abort for this word
o_word_ready  out  1  FIFO can accept a word this cycle
o_instruction  out  32  T: {16'd0, halfword}; ARM: full word
o_instruction_valid  out  1  output qualifier
o_pc  out  32  address of o_instruction
o_iabort  out  1  abort flag travelling with the slot
o_thumb  out  1  slot came from a T-state word

Behaviour:
- Reset values: o_instruction_valid=0, o_iabort=0, o_thumb=0, o_instruction=0, o_pc=0. FIFO is empty, FSM is in S_EMPTY, and o_word_ready=1.
- Accept: a word is accepted when i_word_valid && o_word_ready. o_word_ready = (count < BUF_DEPTH), combinational from registered count. Each entry stores {word, pc, abort, t}.
- FSM states and transitions:
  - S_EMPTY: moves to S_LOW or S_HIGH when the FIFO becomes non-empty.
  - S_LOW: emits word[15:0] at pc, then goes to S_HIGH.
  - S_HIGH: emits word[31:16] at pc+2 (or at pc if pc[1]=1), then pops the entry. Goes to S_LOW/S_HIGH if another entry is present, else S_EMPTY.
  - Entry on head: S_LOW if t && !pc[1] && !abort; S_HIGH if t && pc[1] && !abort.
  - ARM or aborted entry: emits the whole word in a single slot with o_iabort=abort, then pops. Uses S_HIGH encoding with flag whole=1.
- Output register: advances only when !i_stall.
  - Load: loads the current slot with o_instruction_valid=1.
  - Nothing to emit: o_instruction_valid=0.
  - Stall: FSM, FIFO pop and output register are frozen. FIFO push is still permitted if space exists.
- Latency: a word accepted in cycle N produces its first slot in the output register at the end of cycle N+1 (empty FIFO, no stall). Throughput is 1 slot/cycle, so a T-state word occupies 2 cycles.
- Simultaneous push and pop: count is unchanged. The write pointer and read pointer wrap modulo BUF_DEPTH.
- Full: o_word_ready=0, so an offered word is not accepted. The I-cache must hold it.
- i_clear has priority over i_stall and push:
  - Empties the FIFO (pointers and count to 0), sets FSM to S_EMPTY, and clears o_instruction_valid and o_iabort.
  - A word presented in the clear cycle is dropped, and o_word_ready is forced to 0 that cycle.
- i_reset has priority over everything and behaves as a clear plus zeroing of all outputs.
- T bit change mid-stream: each entry uses its own stored t. Entries are never re-split.
- PC arithmetic: 32-bit, wraps modulo 2^32.

Optional Feature:
ZAP_THUMB_SEQ_PERF_EN
- Defined: adds an output o_hw_count[31:0], reset to 0. It increments by 1 on every emitted T-state slot and by 2 on every emitted ARM slot (halfword-equivalents). It holds on stall, is not cleared by i_clear, and saturates at 32'hFFFF_FFFF.
- Undefined: the port and logic are absent, and all other behaviour is identical.

Test Plan:
- T=1, word 32'hB0AA_4801 @pc 0x100, no stall -> output slot 1 is 0x0000_4801 @0x100, then slot 2 is 0x0000_B0AA @0x102, then valid=0.
- T=1, word 32'h1234_5678 @pc 0x202 (pc[1]=1) -> exactly one slot: 0x0000_1234 @0x202.
- T=0, words 0xE3A0_0001 @0x0 and 0xE3A0_1002 @0x4 back-to-back -> two consecutive slots, o_thumb=0, pcs 0x0 and 0x4.
- T=1, push 3 words with i_stall held high -> o_word_ready falls after 2 accepts and the third is held. Release stall -> 6 slots in order with no loss.
- T=1, abort=1 on word @0x300 -> single slot with o_iabort=1 @0x300, and no high-half slot.
- Mid-sequence (S_HIGH pending, FIFO holding 1 word), assert i_clear together with i_word_valid -> next cycle valid=0, count=0, the offered word is not accepted, and the next accepted word is emitted normally.
